// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and encodings for the RV32I multi-cycle control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_RTYPE = 2'b01;
    localparam logic [1:0] ALU_ITYPE = 2'b10;
    localparam logic [1:0] ALU_BR    = 2'b11;

    localparam logic [3:0] CLS_ILLEGAL = 4'd0;
    localparam logic [3:0] CLS_OP      = 4'd1;
    localparam logic [3:0] CLS_OPIMM   = 4'd2;
    localparam logic [3:0] CLS_LOAD    = 4'd3;
    localparam logic [3:0] CLS_STORE   = 4'd4;
    localparam logic [3:0] CLS_BRANCH  = 4'd5;
    localparam logic [3:0] CLS_JAL     = 4'd6;
    localparam logic [3:0] CLS_JALR    = 4'd7;
    localparam logic [3:0] CLS_LUI     = 4'd8;
    localparam logic [3:0] CLS_AUIPC   = 4'd9;

endpackage

`default_nettype wire

// File: rtl/ctrl_opcode_decode.sv
// ============================================================================
// Module      : ctrl_opcode_decode
// Description : Combinational opcode -> {class, imm_type, legal}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_opcode_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic [3:0] o_cls,
    output logic [2:0] o_imm_type,
    output logic       o_legal
);

    always_comb begin
        o_cls      = CLS_ILLEGAL;
        o_imm_type = IMM_I;
        o_legal    = 1'b1;
        case (i_opcode)
            OPC_OP:     o_cls = CLS_OP;
            OPC_OPIMM:  o_cls = CLS_OPIMM;
            OPC_LOAD:   o_cls = CLS_LOAD;
            OPC_JALR:   o_cls = CLS_JALR;
            OPC_STORE:  begin o_cls = CLS_STORE;  o_imm_type = IMM_S; end
            OPC_BRANCH: begin o_cls = CLS_BRANCH; o_imm_type = IMM_B; end
            OPC_LUI:    begin o_cls = CLS_LUI;    o_imm_type = IMM_U; end
            OPC_AUIPC:  begin o_cls = CLS_AUIPC;  o_imm_type = IMM_U; end
            OPC_JAL:    begin o_cls = CLS_JAL;    o_imm_type = IMM_J; end
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module      : multicycle_ctrl
// Description : RV32I multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB).
//               Define MC_ILLEGAL_TRAP_EN to trap on illegal opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [2:0]  imm_type,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  state,
    output logic        illegal
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_cls;
    logic [2:0] w_imm;
    logic       w_legal;
    logic       w_unused_instr;

    assign w_unused_instr = ^instr[31:7];

    ctrl_opcode_decode u_dec (
        .i_opcode   (instr[6:0]),
        .o_cls      (w_cls),
        .o_imm_type (w_imm),
        .o_legal    (w_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    assign state = r_state;

    always_comb begin
        w_next       = r_state;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_PLUS4;
        imm_type     = IMM_I;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        illegal      = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                // Keep the IR quiet while reset holds the FSM in FETCH.
                ir_we   = mem_ready & ~rst;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                imm_type = w_imm;
                if (w_legal) w_next = S_EXEC;
`ifdef MC_ILLEGAL_TRAP_EN
                else         w_next = S_TRAP;
`else
                else         w_next = S_WB;
`endif
            end
            S_EXEC: begin
                imm_type = w_imm;
                w_next   = S_WB;
                case (w_cls)
                    CLS_OP:    alu_op = ALU_RTYPE;
                    CLS_OPIMM: begin alu_src_b = 1'b1; alu_op = ALU_ITYPE; end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_b = 1'b1;
                        w_next    = S_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op = ALU_BR;
                        pc_we  = 1'b1;
                        pc_src = br_taken ? PC_IMM : PC_PLUS4;
                        w_next = S_FETCH;
                    end
                    CLS_JAL: begin
                        pc_we  = 1'b1;
                        pc_src = PC_IMM;
                        rf_we  = 1'b1;
                        wb_sel = WB_PC4;
                        w_next = S_FETCH;
                    end
                    CLS_JALR: begin
                        alu_src_b = 1'b1;
                        pc_we     = 1'b1;
                        pc_src    = PC_ALU;
                        rf_we     = 1'b1;
                        wb_sel    = WB_PC4;
                        w_next    = S_FETCH;
                    end
                    CLS_LUI:   wb_sel = WB_IMM;
                    CLS_AUIPC: begin alu_src_a = 1'b1; alu_src_b = 1'b1; end
                    default:   w_next = S_WB;
                endcase
            end
            S_MEM: begin
                imm_type     = w_imm;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (w_cls == CLS_STORE);
                if (mem_ready) begin
                    if (w_cls == CLS_STORE) begin
                        pc_we  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                imm_type = w_imm;
                // Illegal opcodes pass through here only to advance the PC.
                rf_we    = w_legal;
                pc_we    = 1'b1;
                if (w_cls == CLS_LOAD)     wb_sel = WB_MEM;
                else if (w_cls == CLS_LUI) wb_sel = WB_IMM;
                w_next   = S_FETCH;
            end
            S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`else
                w_next  = S_FETCH;
`endif
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the `imm_type` select of the immediate encoder, the ALU operand muxes, and the PC, IR and register-file write enables. It also runs the request/ready handshake on the shared instruction/data memory port.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: registered IR contents; valid from DECODE onward.
- `mem_ready` in 1: memory completes the current request this cycle.
- `br_taken` in 1: branch comparison result from the ALU, valid in EXEC.
- `ir_we` out 1: IR load strobe.
- `pc_we` out 1: PC load strobe.
- `pc_src` out 2: PC source. 00 = pc+4, 01 = pc+imm, 10 = ALU result with bit0 cleared.
- `imm_type` out 3: immediate encoder select. I=000, S=001, B=010, U=011, J=100.
- `alu_src_a` out 1: 0 = rs1, 1 = PC.
- `alu_src_b` out 1: 0 = rs2, 1 = imm.
- `alu_op` out 2: 00 = add, 01 = R-type funct decode, 10 = I-type funct decode, 11 = branch compare.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: request is a store.
- `mem_addr_sel` out 1: 0 = PC, 1 = ALU result.
- `rf_we` out 1: register-file write enable.
- `wb_sel` out 2: writeback source. 00 = ALU, 01 = memory, 10 = pc+4, 11 = imm.
- `state` out 3: current FSM state, for debug.
- `illegal` out 1: illegal-instruction flag.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- All outputs are decoded from `state`, `instr[6:0]`, `mem_ready` and `br_taken`. Any output not listed as asserted in a state is 0.
- FETCH
  - `mem_req`=1, `mem_addr_sel`=0.
  - Hold while `mem_ready`=0.
  - When `mem_ready`=1: `ir_we`=1, then go to DECODE.
- DECODE
  - `imm_type` is decoded from the opcode. LOAD, OP-IMM and JALR give 000. STORE gives 001. BRANCH gives 010. LUI and AUIPC give 011. JAL gives 100. OP and illegal opcodes give 000.
  - `imm_type` holds this value in DECODE, EXEC, MEM and WB. It is 000 in FETCH and TRAP.
  - Next state is EXEC.
- EXEC
  - OP: `alu_op`=01, go to WB.
  - OP-IMM: `alu_src_b`=1, `alu_op`=10, go to WB.
  - LOAD/STORE: `alu_src_b`=1, `alu_op`=00, go to MEM.
  - BRANCH: `alu_op`=11, `pc_we`=1, `pc_src`=01 if `br_taken` else 00, go to FETCH.
  - JAL: `pc_we`=1, `pc_src`=01, `rf_we`=1, `wb_sel`=10, go to FETCH.
  - JALR: `alu_src_b`=1, `pc_we`=1, `pc_src`=10, `rf_we`=1, `wb_sel`=10, go to FETCH.
  - LUI: go to WB with `wb_sel`=11.
  - AUIPC: `alu_src_a`=1, `alu_src_b`=1, go to WB.
- MEM
  - `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for STORE.
  - Hold while `mem_ready`=0.
  - On `mem_ready`=1: a STORE asserts `pc_we`=1 with `pc_src`=00 and goes to FETCH. A LOAD goes to WB.
- WB
  - `rf_we`=1, `pc_we`=1, `pc_src`=00, then go to FETCH.
  - `wb_sel` is 01 for LOAD, 11 for LUI, 00 otherwise.
- `rd`=x0 filtering is the register file's job, not this block's.

## Timing
- Reset:
  - While `rst` is high, `state`=FETCH.
  - Consequently `mem_req`=1 and every other output is 0.
  - Assertion at any point aborts the instruction in flight with no PC or register write.
- Minimum cycles per instruction with zero-wait memory:
  - BRANCH, JAL, JALR: 3.
  - OP, OP-IMM, LUI, AUIPC, STORE: 4.
  - LOAD: 5.
- Each cycle with `mem_ready`=0 in FETCH or MEM adds exactly one cycle.
- `mem_req` stays high, and `mem_we`/`mem_addr_sel` stay stable, from the first request cycle up to and including the `mem_ready` cycle.
- `ir_we` and `pc_we` are one-cycle pulses. `pc_we` fires exactly once per retired instruction.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An opcode outside the RV32I set listed above moves DECODE to TRAP.
  - TRAP asserts `illegal`=1 with all enables 0.
  - TRAP is left only by reset.
- Undefined:
  - An illegal opcode moves DECODE to WB with `rf_we` forced 0, so only the PC advances by 4.
  - TRAP is unreachable and `illegal` is tied to 0.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum;
  - opcode localparams (LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111, OP=0110011, OP-IMM=0010011, LUI=0110111, AUIPC=0010111);
  - `imm_type` codes shared with the immediate encoder;
  - `pc_src`, `wb_sel` and `alu_op` codes.
- One sub-module, `ctrl_opcode_decode`: combinational opcode to {class, `imm_type`, legal}.

## Test plan
- ADDI x1,x0,5 (0x00500093) with zero-wait memory:
  - States FETCH, DECODE, EXEC, WB over 4 cycles.
  - `imm_type`=000 from DECODE through WB.
  - `rf_we` and `pc_we` pulse once, in WB.
- SW (0x0020A223) with `mem_ready` held low 3 cycles in MEM:
  - `mem_req`, `mem_we` and `mem_addr_sel`=1 stable for 4 cycles.
  - `imm_type`=001.
  - `pc_we` asserts on the ready cycle.
- BEQ:
  - `br_taken`=1 gives `pc_src`=01; `br_taken`=0 gives `pc_src`=00.
  - `imm_type`=010 in both cases.
  - 3 cycles, `rf_we` never set.
- LW then JAL back-to-back:
  - LW takes 5 cycles with `wb_sel`=01.
  - JAL takes 3 cycles with `imm_type`=100, `wb_sel`=10, `pc_src`=01.
- `rst` asserted mid-MEM of a load:
  - `state` goes to FETCH immediately.
  - `rf_we` and `pc_we` stay 0.
  - `mem_req`=1 and `mem_we`=0 while reset is held.
- Opcode 0x0000007F:
  - With the macro: TRAP, `illegal`=1 held.
  - Without it: PC advances, `rf_we`=0, next fetch follows.
